// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with programmable access latency
module dmem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]   mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] word_idx;
    logic          acc_err;

    // BASE_ADDR is DEPTH*4 aligned, so the window test reduces to matching the
    // upper address bits and the word index is just the middle slice.
    assign word_idx = addr_q[AW+1:2];
    assign acc_err  = (addr_q[1:0] != 2'b00) ||
                      (addr_q[31:AW+2] != BASE_ADDR[31:AW+2]);

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    err_d   = acc_err;
                    rdata_d = (acc_err || we_q) ? 32'h0 : mem[word_idx];
                    mem_we  = we_q && !acc_err;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; reset forces IDLE so an unstarted store never commits.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized scoreboard bench for dmem_responder
module tb_dmem_responder;

    localparam int          DEPTH = 256;
    localparam int          W     = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model_mem [DEPTH];
    logic [32:0] exp_q [$];
    bit          rand_done;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: word-addressed array behind a byte-address window, faults on
    // misalignment or addresses outside the window. Returns {rdata, err}.
    function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr,
                                                 input logic [31:0] wdata, input logic [3:0] be);
        longint a   = longint'(addr);
        longint b   = longint'(BASE);
        bit     err = (a % 4 != 0) || (a < b) || (a >= b + 4 * DEPTH);
        int     idx;
        if (err) return {32'h0, 1'b1};
        idx = int'((a - b) / 4);
        if (we) begin
            for (int l = 0; l < 4; l++)
                if (be[l]) model_mem[idx][8*l +: 8] = wdata[8*l +: 8];
            return {32'h0, 1'b0};
        end
        return {model_mem[idx], 1'b0};
    endfunction

    // Monitor: every cycle a response is shown it must match the oldest
    // expectation; it is retired only on the handshake cycle.
    always @(negedge clk) begin
        if (!areset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got rdata %h err %b expected no response", rsp_rdata, rsp_err);
            end else begin
                chk("rsp_rdata", rsp_rdata, exp_q[0][32:1]);
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_q[0][0]});
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || !req_ready) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() != 0 || !req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
    endtask

    // Issues one request; returns just after the accept edge, or after the
    // response edge when check_lat is set.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit check_lat, input bit wait_done);
        int guard = 0;
        @(posedge clk); #1;
        drive_req(we, addr, wdata, be);
        while (!req_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1");
        end
        @(posedge clk);
        exp_q.push_back(model_access(we, addr, wdata, be));
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (check_lat) begin
            for (int i = 0; i < W; i++) begin
                @(posedge clk); #1;
                chk("lat_early_valid", {31'h0, rsp_valid}, 32'h0);
            end
            @(posedge clk); #1;
            chk("lat_valid", {31'h0, rsp_valid}, 32'h1);
        end
        if (wait_done) drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        areset    = 1'b1;
        rsp_ready = 1'b1;
        drive_req(1'b1, 32'h10, 32'h1234_5678, 4'hF);
        rand_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
            chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            chk("rst_rsp_rdata", rsp_rdata, 32'h0);
            chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        end
        @(posedge clk); #1;
        areset    = 1'b0;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < DEPTH; i++)
            issue(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 1'b0, 1'b1);

        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b1);
        issue(1'b1, 32'h10, 32'h0000_5500, 4'b0010, 1'b1, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b1);

        // Held response under back-pressure with a competing request.
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0);
        drive_req(1'b1, 32'h14, 32'h1122_3344, 4'hF);
        repeat (5) begin
            chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", {31'h0, req_ready}, 32'h1);
        chk("bp_release_valid", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk);
        exp_q.push_back(model_access(1'b1, 32'h14, 32'h1122_3344, 4'hF));
        #1;
        req_valid = 1'b0;
        chk("bp_second_accepted", {31'h0, req_ready}, 32'h0);
        drain();
        issue(1'b0, 32'h14, 32'h0, 4'h0, 1'b1, 1'b1);

        issue(1'b0, 32'h13, 32'h0, 4'hF, 1'b1, 1'b1);
        issue(1'b1, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
        issue(1'b1, 32'h8, 32'hCAFE_F00D, 4'b0000, 1'b1, 1'b1);
        issue(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 1'b1);

        // Reset before the access edge must discard the pending store.
        issue(1'b1, 32'h20, 32'hAAAA_AAAA, 4'hF, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive_req(1'b1, 32'h20, 32'h1234_5678, 4'hF);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("midop_accepted", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        chk("midop_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("midop_rst_valid", {31'h0, rsp_valid}, 32'h0);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b1);

        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    logic [31:0] a;
                    int          kind = $urandom_range(0, 9);
                    a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                    if (kind == 7) a = a + 32'($urandom_range(1, 3));
                    else if (kind == 8) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 4000));
                    else if (kind == 9) a = $urandom;
                    issue(1'($urandom), a, $urandom, 4'($urandom), 1'b1, 1'b1);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
                rsp_ready = 1'b1;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
